pll_sequencer: RTL and testbench

PLL_SEQUENCER -- requirements
Module: pll_sequencer

---
 rtl/pll_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_pll_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_sequencer.sv
// PLL start-up sequencer: pulses PLL RESETB, waits for a synchronised lock, holds
// downstream reset until the lock has been stable, and re-sequences on loss or restart.
// Optional macro PLL_SEQ_RETRY_LIMIT_EN: after MAX_RETRIES timeouts the sequencer parks in FAIL.
module pll_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       locked,
    input  logic       restart,
    output logic       pll_resetb,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_count,
    output logic       lock_lost
);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam logic [15:0] RESET_LAST  = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);
`endif

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] count_r;
    logic [15:0] count_nxt_s;
    logic        lock_meta_r;
    logic        lock_sync_r;
    logic [3:0]  retry_r;
    logic [3:0]  retry_nxt_s;
    logic        lost_r;
    logic        lost_nxt_s;
    logic        fail_nxt_s;
    logic        pll_resetb_r;
    logic        sys_reset_r;
    logic        ready_r;
    logic        fail_r;

    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        if (value == 4'd15) begin
            return value;
        end else begin
            return value + 4'd1;
        end
    endfunction

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= locked;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Next-state, retry and loss-flag decode; restart overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        retry_nxt_s = retry_r;
        lost_nxt_s  = lost_r;
        if (restart) begin
            state_nxt_s = RESET_PLL;
            retry_nxt_s = 4'd0;
            lost_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                RESET_PLL: begin
                    if (count_r == RESET_LAST) begin
                        state_nxt_s = WAIT_LOCK;
                    end else begin
                        state_nxt_s = RESET_PLL;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_sync_r) begin
                        state_nxt_s = STABLE;
                    end else if (count_r == LOCK_LAST) begin
`ifdef PLL_SEQ_RETRY_LIMIT_EN
                        if (retry_r == RETRY_LIMIT) begin
                            state_nxt_s = FAIL;
                        end else begin
                            state_nxt_s = RESET_PLL;
                            retry_nxt_s = sat_inc(retry_r);
                        end
`else
                        state_nxt_s = RESET_PLL;
                        retry_nxt_s = sat_inc(retry_r);
`endif
                    end else begin
                        state_nxt_s = WAIT_LOCK;
                    end
                end
                STABLE: begin
                    if (!lock_sync_r) begin
                        state_nxt_s = WAIT_LOCK;
                    end else if (count_r == STABLE_LAST) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = STABLE;
                    end
                end
                RUN: begin
                    if (!lock_sync_r) begin
                        state_nxt_s = RESET_PLL;
                        lost_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                FAIL: begin
`ifdef PLL_SEQ_RETRY_LIMIT_EN
                    state_nxt_s = FAIL;
`else
                    state_nxt_s = RESET_PLL;
`endif
                end
                default: begin
                    state_nxt_s = RESET_PLL;
                end
            endcase
        end
    end

    // Cycle counter restarts on every state change and on restart; it saturates while idle in a state.
    always_comb begin
        count_nxt_s = count_r;
        if (restart || (state_nxt_s != state_r)) begin
            count_nxt_s = 16'd0;
        end else if (count_r != 16'hFFFF) begin
            count_nxt_s = count_r + 16'd1;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // The fail flag only exists when the retry limit is built in.
    always_comb begin
`ifdef PLL_SEQ_RETRY_LIMIT_EN
        fail_nxt_s = (state_nxt_s == FAIL);
`else
        fail_nxt_s = 1'b0;
`endif
    end

    // State, counter, status flags and registered output decode (aligned with the state register).
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_r      <= RESET_PLL;
            count_r      <= 16'd0;
            retry_r      <= 4'd0;
            lost_r       <= 1'b0;
            pll_resetb_r <= 1'b0;
            sys_reset_r  <= 1'b1;
            ready_r      <= 1'b0;
            fail_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            count_r      <= count_nxt_s;
            retry_r      <= retry_nxt_s;
            lost_r       <= lost_nxt_s;
            pll_resetb_r <= !((state_nxt_s == RESET_PLL) || (state_nxt_s == FAIL));
            sys_reset_r  <= (state_nxt_s != RUN);
            ready_r      <= (state_nxt_s == RUN);
            fail_r       <= fail_nxt_s;
        end
    end

    assign pll_resetb  = pll_resetb_r;
    assign sys_reset   = sys_reset_r;
    assign ready       = ready_r;
    assign fail        = fail_r;
    assign retry_count = retry_r;
    assign lock_lost   = lost_r;

endmodule

// File: tb/tb_pll_sequencer.sv
// Directed bench for pll_sequencer with small timing parameters; expected values are
// hand-derived per cycle (cycle 0 = last edge with reset high). Adapts to PLL_SEQ_RETRY_LIMIT_EN.
module tb_pll_sequencer;

    logic       clock_in;
    logic       reset;
    logic       locked;
    logic       restart;
    logic       pll_resetb;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;
    logic       lock_lost;

    int tests_run;
    int tests_failed;
    int cyc;

    pll_sequencer #(
        .RESET_CYCLES (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .locked     (locked),
        .restart    (restart),
        .pll_resetb (pll_resetb),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .fail       (fail),
        .retry_count(retry_count),
        .lock_lost  (lock_lost)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run = tests_run + 1;
        if (obs !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset(input string tag);
        reset   = 1'b1;
        restart = 1'b0;
        tick();
        tick();
        cyc = 0;
        check_eq({tag, "_rst_resetb"}, 16'(pll_resetb), 16'd0);
        check_eq({tag, "_rst_sysrst"}, 16'(sys_reset), 16'd1);
        check_eq({tag, "_rst_ready"}, 16'(ready), 16'd0);
        check_eq({tag, "_rst_fail"}, 16'(fail), 16'd0);
        check_eq({tag, "_rst_retry"}, 16'(retry_count), 16'd0);
        check_eq({tag, "_rst_lost"}, 16'(lock_lost), 16'd0);
        reset = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        reset        = 1'b1;
        locked       = 1'b0;
        restart      = 1'b0;

        // Nominal: RESET_PLL cycles 0..3, WAIT_LOCK 4, STABLE 5..12, RUN from 13.
        locked = 1'b1;
        do_reset("nom");
        tick_to(3);
        check_eq("nom_resetb_c3", 16'(pll_resetb), 16'd0);
        tick_to(4);
        check_eq("nom_resetb_c4", 16'(pll_resetb), 16'd1);
        tick_to(12);
        check_eq("nom_ready_c12", 16'(ready), 16'd0);
        check_eq("nom_sysrst_c12", 16'(sys_reset), 16'd1);
        tick_to(13);
        check_eq("nom_ready_c13", 16'(ready), 16'd1);
        check_eq("nom_sysrst_c13", 16'(sys_reset), 16'd0);
        check_eq("nom_retry", 16'(retry_count), 16'd0);

        // Glitch at STABLE cycle 5: back to WAIT_LOCK at 13, STABLE 14..21, RUN at 22.
        locked = 1'b1;
        do_reset("gl");
        tick_to(10);
        locked = 1'b0;
        tick_to(11);
        locked = 1'b1;
        tick_to(13);
        check_eq("gl_ready_c13", 16'(ready), 16'd0);
        check_eq("gl_resetb_c13", 16'(pll_resetb), 16'd1);
        tick_to(21);
        check_eq("gl_ready_c21", 16'(ready), 16'd0);
        tick_to(22);
        check_eq("gl_ready_c22", 16'(ready), 16'd1);
        check_eq("gl_retry", 16'(retry_count), 16'd0);

        // Lock arriving exactly on the timeout cycle wins: STABLE at 24, RUN at 32, no retry.
        locked = 1'b0;
        do_reset("edge");
        tick_to(21);
        locked = 1'b1;
        tick_to(24);
        check_eq("edge_retry_c24", 16'(retry_count), 16'd0);
        check_eq("edge_resetb_c24", 16'(pll_resetb), 16'd1);
        tick_to(31);
        check_eq("edge_ready_c31", 16'(ready), 16'd0);
        tick_to(32);
        check_eq("edge_ready_c32", 16'(ready), 16'd1);

        // Timeout loop: retries at 24 and 48, lock after 60, STABLE 63..70, RUN 71.
        locked = 1'b0;
        do_reset("to");
        tick_to(23);
        check_eq("to_retry_c23", 16'(retry_count), 16'd0);
        check_eq("to_resetb_c23", 16'(pll_resetb), 16'd1);
        tick_to(24);
        check_eq("to_retry_c24", 16'(retry_count), 16'd1);
        check_eq("to_resetb_c24", 16'(pll_resetb), 16'd0);
        tick_to(27);
        check_eq("to_resetb_c27", 16'(pll_resetb), 16'd0);
        tick_to(28);
        check_eq("to_resetb_c28", 16'(pll_resetb), 16'd1);
        tick_to(48);
        check_eq("to_retry_c48", 16'(retry_count), 16'd2);
        tick_to(60);
        locked = 1'b1;
        tick_to(70);
        check_eq("to_ready_c70", 16'(ready), 16'd0);
        tick_to(71);
        check_eq("to_ready_c71", 16'(ready), 16'd1);
        check_eq("to_sysrst_c71", 16'(sys_reset), 16'd0);
        check_eq("to_retry_c71", 16'(retry_count), 16'd2);
        check_eq("to_fail_c71", 16'(fail), 16'd0);

        // Lock never arrives: third timeout at 72 either parks in FAIL or keeps retrying.
        locked = 1'b0;
        do_reset("lim");
        tick_to(71);
        check_eq("lim_retry_c71", 16'(retry_count), 16'd2);
        check_eq("lim_resetb_c71", 16'(pll_resetb), 16'd1);
        tick_to(72);
        check_eq("lim_resetb_c72", 16'(pll_resetb), 16'd0);
        check_eq("lim_sysrst_c72", 16'(sys_reset), 16'd1);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
        check_eq("lim_fail_c72", 16'(fail), 16'd1);
        check_eq("lim_retry_c72", 16'(retry_count), 16'd2);
        tick_to(96);
        check_eq("lim_fail_c96", 16'(fail), 16'd1);
        check_eq("lim_retry_c96", 16'(retry_count), 16'd2);
`else
        check_eq("lim_fail_c72", 16'(fail), 16'd0);
        check_eq("lim_retry_c72", 16'(retry_count), 16'd3);
        tick_to(96);
        check_eq("lim_fail_c96", 16'(fail), 16'd0);
        check_eq("lim_retry_c96", 16'(retry_count), 16'd4);
`endif
        restart = 1'b1;
        tick_to(97);
        restart = 1'b0;
        check_eq("rs_fail_c97", 16'(fail), 16'd0);
        check_eq("rs_retry_c97", 16'(retry_count), 16'd0);
        check_eq("rs_resetb_c97", 16'(pll_resetb), 16'd0);
        tick_to(100);
        check_eq("rs_resetb_c100", 16'(pll_resetb), 16'd0);
        tick_to(101);
        check_eq("rs_resetb_c101", 16'(pll_resetb), 16'd1);
        tick_to(481);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
        check_eq("sat_retry_c481", 16'(retry_count), 16'd2);
        check_eq("sat_fail_c481", 16'(fail), 16'd1);
`else
        check_eq("sat_retry_c481", 16'(retry_count), 16'd15);
        check_eq("sat_fail_c481", 16'(fail), 16'd0);
`endif

        // Lock lost in RUN: drop after 15, RESET_PLL at 18..21, relock, RUN again at 31.
        locked = 1'b1;
        do_reset("loss");
        tick_to(15);
        locked = 1'b0;
        tick_to(17);
        check_eq("loss_ready_c17", 16'(ready), 16'd1);
        check_eq("loss_lost_c17", 16'(lock_lost), 16'd0);
        tick_to(18);
        locked = 1'b1;
        check_eq("loss_sysrst_c18", 16'(sys_reset), 16'd1);
        check_eq("loss_lost_c18", 16'(lock_lost), 16'd1);
        check_eq("loss_resetb_c18", 16'(pll_resetb), 16'd0);
        check_eq("loss_ready_c18", 16'(ready), 16'd0);
        tick_to(21);
        check_eq("loss_resetb_c21", 16'(pll_resetb), 16'd0);
        tick_to(22);
        check_eq("loss_resetb_c22", 16'(pll_resetb), 16'd1);
        tick_to(31);
        check_eq("loss_ready_c31", 16'(ready), 16'd1);
        check_eq("loss_lost_c31", 16'(lock_lost), 16'd1);
        check_eq("loss_retry_c31", 16'(retry_count), 16'd0);

        // Reset together with restart while in RUN behaves as a plain reset.
        reset   = 1'b1;
        restart = 1'b1;
        tick();
        check_eq("rr_resetb", 16'(pll_resetb), 16'd0);
        check_eq("rr_sysrst", 16'(sys_reset), 16'd1);
        check_eq("rr_ready", 16'(ready), 16'd0);
        check_eq("rr_lost", 16'(lock_lost), 16'd0);
        reset   = 1'b0;
        restart = 1'b0;

        // Reset while in STABLE (cycle 7) restarts the whole sequence.
        locked = 1'b1;
        do_reset("mid");
        tick_to(7);
        check_eq("mid_resetb_c7", 16'(pll_resetb), 16'd1);
        reset = 1'b1;
        tick();
        check_eq("mid_resetb_rst", 16'(pll_resetb), 16'd0);
        check_eq("mid_sysrst_rst", 16'(sys_reset), 16'd1);
        check_eq("mid_ready_rst", 16'(ready), 16'd0);
        reset = 1'b0;
        cyc   = 0;
        tick_to(3);
        check_eq("mid_resetb_c3", 16'(pll_resetb), 16'd0);
        tick_to(4);
        check_eq("mid_resetb_c4", 16'(pll_resetb), 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
